// File: rtl/mmio_responder.sv
// MMIO responder: 16-word register window in dmem space (button FIFO, timer, LEDs, score).
// Define MMIO_TIMER_EN to build the tick timer; without it TIMER reads 0 and TIMER_CTRL is ignored.
module mmio_responder #(
    parameter logic [11:0] BASE_ADDR  = 12'hFF0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMER_DIV  = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_mmio,
    output logic        sel,
    input  logic [3:0]  btn,
    output logic [7:0]  leds,
    output logic [31:0] score
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OFF_STATUS = 4'd0;
    localparam logic [3:0] OFF_EVENT  = 4'd1;
    localparam logic [3:0] OFF_TIMER  = 4'd2;
    localparam logic [3:0] OFF_TCTRL  = 4'd3;
    localparam logic [3:0] OFF_LEDS   = 4'd4;
    localparam logic [3:0] OFF_SCORE  = 4'd5;

    logic [3:0]       btn_q;
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       leds_q;
    logic [31:0]      score_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             sel_q;
    logic [31:0]      timer_val;

    logic        hit, rd_en, wr_en;
    logic [3:0]  offset;
    logic [3:0]  new_evt;
    logic        empty, full, push_req, push, pop;

    assign hit    = (address_dmem[11:4] == BASE_ADDR[11:4]);
    assign offset = address_dmem[3:0];
    assign rd_en  = hit && !wren;
    assign wr_en  = hit && wren;

    assign new_evt  = btn & ~btn_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = rd_en && (offset == OFF_EVENT) && !empty;
    assign push_req = |new_evt;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    logic unused_addr;
    assign unused_addr = ^address_dmem[31:12];

`ifdef MMIO_TIMER_EN
    localparam int PRESC_W = $clog2(TIMER_DIV);
    logic [PRESC_W-1:0] presc_q;
    logic [31:0]        tick_q;
    logic               tctrl_wr;

    assign tctrl_wr  = wr_en && (offset == OFF_TCTRL);
    assign timer_val = tick_q;

    always_ff @(posedge clock) begin
        if (reset || tctrl_wr) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else if (presc_q == PRESC_W'(TIMER_DIV - 1)) begin
            presc_q <= '0;
            tick_q  <= tick_q + 32'd1;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end
`else
    localparam int unused_timer_div = TIMER_DIV;
    assign timer_val = 32'd0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        count_d    = count_q;
        overflow_d = overflow_q;
        rdata_d    = 32'd0;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (wr_en && (offset == OFF_STATUS) && data[2]) overflow_d = 1'b0;
        if (push_req && full && !pop)                   overflow_d = 1'b1;
        if (rd_en) begin
            case (offset)
                OFF_STATUS: rdata_d = {24'd0, 5'(count_q), overflow_q, full, !empty};
                OFF_EVENT:  rdata_d = empty ? 32'd0 : {28'd0, fifo_mem[rd_ptr_q]};
                OFF_TIMER:  rdata_d = timer_val;
                OFF_LEDS:   rdata_d = {24'd0, leds_q};
                OFF_SCORE:  rdata_d = score_q;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_q      <= 4'hF;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            leds_q     <= 8'd0;
            score_q    <= 32'd0;
            rdata_q    <= 32'd0;
            sel_q      <= 1'b0;
        end else begin
            btn_q      <= btn;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
            sel_q      <= hit;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wr_en && (offset == OFF_LEDS))  leds_q  <= data[7:0];
            if (wr_en && (offset == OFF_SCORE)) score_q <= data;
        end
    end

    // NOTE: FIFO storage has no reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (!reset && push) fifo_mem[wr_ptr_q] <= new_evt;
    end

    assign q_mmio = rdata_q;
    assign sel    = sel_q;
    assign leds   = leds_q;
    assign score  = score_q;
endmodule
